// File: rtl/sm_window_mean.sv
// Window mean of sign-magnitude error samples, emitted in sign-magnitude with a one-cycle valid pulse.
// Optional per-window peak magnitude tracking is enabled by defining PEAK_TRACK_EN.
module sm_window_mean #(
  parameter int WIDTH  = 24,
  parameter int WINDOW = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       clear,
  output logic [WIDTH-1:0]           mean_out,
  output logic                       mean_valid,
  output logic [$clog2(WINDOW)-1:0]  sample_cnt,
  output logic [WIDTH-2:0]           peak_out
);

  localparam int CW = $clog2(WINDOW);
  localparam int AW = WIDTH + CW;

  typedef enum logic [1:0] {ACC, CONV, OUT} state_t;

  state_t               state, state_nxt;
  logic signed [AW-1:0] acc, tot_r, samp_p0;
  logic [CW-1:0]        cnt;
  logic                 win_end_p0;

  // Sign-magnitude to two's complement; negative zero collapses to 0 on its own.
  function automatic logic signed [AW-1:0] conv(input logic [WIDTH-1:0] s);
    logic signed [AW-1:0] m;
    m = $signed({{(CW+1){1'b0}}, s[WIDTH-2:0]});
    return s[WIDTH-1] ? -m : m;
  endfunction

  // |tot| fits in AW-1 bits, so the low AW-1 bits of the negation are exact.
  function automatic logic [WIDTH-1:0] to_sm_mean(input logic signed [AW-1:0] tot);
    logic [AW-2:0]    a;
    logic [WIDTH-2:0] m;
    a = tot[AW-1] ? (~tot[AW-2:0] + 1'b1) : tot[AW-2:0];
    m = (WIDTH-1)'(a >> CW);
    return {tot[AW-1] && (m != '0), m};
  endfunction

  assign samp_p0    = conv(din);
  assign win_end_p0 = din_valid && (cnt == CW'(WINDOW-1));
  assign sample_cnt = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (win_end_p0) state_nxt = CONV;
      CONV:    state_nxt = OUT;
      OUT:     state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
    if (clear) state_nxt = ACC;
  end

  // Stage p0: accumulate; stage p1: tot_r holds the closed window while the next one fills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      tot_r      <= '0;
      mean_out   <= '0;
      mean_valid <= 1'b0;
    end else begin
      mean_valid <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        if (din_valid) begin
          if (win_end_p0) begin
            tot_r <= acc + samp_p0;
            acc   <= '0;
            cnt   <= '0;
          end else begin
            acc <= acc + samp_p0;
            cnt <= cnt + CW'(1);
          end
        end
        // Stage p2: publish the mean of the window closed two cycles ago.
        if (state == CONV) begin
          mean_out   <= to_sm_mean(tot_r);
          mean_valid <= 1'b1;
        end
      end
    end
  end

`ifdef PEAK_TRACK_EN
  logic [WIDTH-2:0] peak_run, peak_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_run <= '0;
      peak_win <= '0;
      peak_out <= '0;
    end else if (clear) begin
      peak_run <= '0;
    end else begin
      if (din_valid) begin
        if (win_end_p0) begin
          peak_win <= (din[WIDTH-2:0] > peak_run) ? din[WIDTH-2:0] : peak_run;
          peak_run <= '0;
        end else if (din[WIDTH-2:0] > peak_run) begin
          peak_run <= din[WIDTH-2:0];
        end
      end
      if (state == CONV) peak_out <= peak_win;
    end
  end
`else
  assign peak_out = '0;
`endif

endmodule
